// File: rtl/hex_pkg.sv
// Shared types and constants for the arbitrated four-digit hex writer front end.
package hex_pkg;

    localparam int HEX_DIGITS = 4;
    localparam int HEX_NIB    = 4;
    localparam int HEX_WORD   = 16;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        SPACE,
        DONE
    } state_t;

    function automatic logic [HEX_NIB-1:0] nibble(input logic [HEX_WORD-1:0] word,
                                                  input logic [1:0]          idx);
        return word[{idx, 2'b00} +: HEX_NIB];
    endfunction

endpackage

// File: rtl/hex_update_arb_if.sv
// Requester and hex-writer signal bundle; master drives requests, slave is the arbiter.
interface hex_update_arb_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    req;
    logic [16*NREQ-1:0] data;
    logic [NREQ-1:0]    ack;
    logic               busy;
    logic [1:0]         owner;
    logic               hex_en;
    logic [3:0]         hex_val;
    logic [1:0]         hex_dig;

    modport master (
        output req, data,
        input  ack, busy, owner, hex_en, hex_val, hex_dig
    );

    modport slave (
        input  req, data,
        output ack, busy, owner, hex_en, hex_val, hex_dig
    );
endinterface

// File: rtl/hex_update_arb_rr_arb.sv
// Combinational round-robin picker: searches from (last+1) mod NREQ upward.
module rr_arb #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    output logic [1:0]      gnt_idx,
    output logic            gnt_vld
);
    logic [1:0]      w_cand [NREQ];
    logic [NREQ-1:0] w_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            assign w_cand[gi] = 2'((32'(last) + gi + 1) % NREQ);
            assign w_hit[gi]  = |(req & (NREQ'(1) << w_cand[gi]));
        end
    endgenerate

    // Walk from lowest to highest priority so the nearest candidate wins last.
    always_comb begin
        gnt_idx = 2'd0;
        gnt_vld = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                gnt_idx = w_cand[k];
                gnt_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/hex_update_arb.sv
// Shares one four-digit hex writer among NREQ requesters, writing one nibble per cycle
// with GAP idle cycles between digits and a one-cycle ack to the grantee at the end.
module hex_update_arb
    import hex_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int GAP  = 0
) (
    input  logic             clk,
    input  logic             rst,
    hex_update_arb_if.slave  bus
);
    state_t            r_state, w_state_next;
    logic [15:0]       r_shadow, w_shadow_next;
    logic [1:0]        r_dig, w_dig_next;
    logic [3:0]        r_gap, w_gap_next;
    logic [1:0]        r_last, w_last_next;
    logic [1:0]        r_owner, w_owner_next;
    logic              r_hex_en, w_hex_en_next;
    logic [3:0]        r_hex_val, w_hex_val_next;
    logic [1:0]        r_hex_dig, w_hex_dig_next;
    logic [NREQ-1:0]   r_ack, w_ack_next;
    logic              r_busy, w_busy_next;

    logic [1:0]        w_gnt_idx;
    logic              w_gnt_vld;
    logic [15:0]       w_gnt_word;

    rr_arb #(.NREQ(NREQ)) u_rr_arb (
        .req     (bus.req),
        .last    (r_last),
        .gnt_idx (w_gnt_idx),
        .gnt_vld (w_gnt_vld)
    );

    always_comb begin
        w_gnt_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == 2'(i)) w_gnt_word = bus.data[16*i +: 16];
        end
    end

    // Outputs are computed for the state being entered so they appear registered.
    always_comb begin
        w_state_next   = r_state;
        w_shadow_next  = r_shadow;
        w_dig_next     = r_dig;
        w_gap_next     = r_gap;
        w_last_next    = r_last;
        w_owner_next   = r_owner;
        w_hex_en_next  = 1'b0;
        w_hex_val_next = r_hex_val;
        w_hex_dig_next = r_hex_dig;
        w_ack_next     = '0;
        w_busy_next    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_vld) begin
                    w_state_next   = WRITE;
                    w_shadow_next  = w_gnt_word;
                    w_owner_next   = w_gnt_idx;
                    w_dig_next     = 2'd0;
                    w_hex_en_next  = 1'b1;
                    w_hex_dig_next = 2'd0;
                    w_hex_val_next = nibble(w_gnt_word, 2'd0);
                    w_busy_next    = 1'b1;
                end
            end
            WRITE: begin
                w_busy_next = 1'b1;
                if (r_dig == 2'(HEX_DIGITS - 1)) begin
                    w_state_next = DONE;
                    w_ack_next   = NREQ'(1) << r_owner;
                end else if (GAP == 0) begin
                    w_dig_next     = r_dig + 2'd1;
                    w_hex_en_next  = 1'b1;
                    w_hex_dig_next = r_dig + 2'd1;
                    w_hex_val_next = nibble(r_shadow, r_dig + 2'd1);
                end else begin
                    w_state_next = SPACE;
                    w_gap_next   = 4'(GAP - 1);
                    w_dig_next   = r_dig + 2'd1;
                end
            end
            SPACE: begin
                w_busy_next = 1'b1;
                if (r_gap == 4'd0) begin
                    w_state_next   = WRITE;
                    w_hex_en_next  = 1'b1;
                    w_hex_dig_next = r_dig;
                    w_hex_val_next = nibble(r_shadow, r_dig);
                end else begin
                    w_gap_next = r_gap - 4'd1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
                w_last_next  = r_owner;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shadow  <= '0;
            r_dig     <= '0;
            r_gap     <= '0;
            r_last    <= 2'(NREQ - 1);
            r_owner   <= '0;
            r_hex_en  <= 1'b0;
            r_hex_val <= '0;
            r_hex_dig <= '0;
            r_ack     <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shadow  <= w_shadow_next;
            r_dig     <= w_dig_next;
            r_gap     <= w_gap_next;
            r_last    <= w_last_next;
            r_owner   <= w_owner_next;
            r_hex_en  <= w_hex_en_next;
            r_hex_val <= w_hex_val_next;
            r_hex_dig <= w_hex_dig_next;
            r_ack     <= w_ack_next;
            r_busy    <= w_busy_next;
        end
    end

    assign bus.ack     = r_ack;
    assign bus.busy    = r_busy;
    assign bus.owner   = r_owner;
    assign bus.hex_en  = r_hex_en;
    assign bus.hex_val = r_hex_val;
    assign bus.hex_dig = r_hex_dig;
endmodule

// File: tb/tb_hex_update_arb.sv
// Directed bench for hex_update_arb: three configurations share one clock and reset;
// a scoreboard of expected writes/acks is filled at request time and drained by monitors.
module tb_hex_update_arb;

    typedef struct packed {
        logic       is_ack;
        logic [1:0] owner;
        logic [1:0] dig;
        logic [3:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    hex_update_arb_if #(.NREQ(2)) ia ();
    hex_update_arb_if #(.NREQ(2)) ig ();
    hex_update_arb_if #(.NREQ(4)) iq ();

    hex_update_arb #(.NREQ(2), .GAP(0)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    hex_update_arb #(.NREQ(2), .GAP(2)) dut_g (.clk(clk), .rst(rst), .bus(ig));
    hex_update_arb #(.NREQ(4), .GAP(0)) dut_q (.clk(clk), .rst(rst), .bus(iq));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input int id, input logic [1:0] own, input logic [15:0] word,
                            input int ndig, input bit with_ack);
        exp_t e;
        for (int d = 0; d < ndig; d++) begin
            e.is_ack = 1'b0;
            e.owner  = own;
            e.dig    = 2'(d);
            e.val    = 4'((word >> (4 * d)) & 16'hF);
            if (id == 0) q0.push_back(e);
            else if (id == 1) q1.push_back(e);
            else q2.push_back(e);
        end
        if (with_ack) begin
            e = '{is_ack: 1'b1, owner: own, dig: 2'd0, val: 4'd0};
            if (id == 0) q0.push_back(e);
            else if (id == 1) q1.push_back(e);
            else q2.push_back(e);
        end
    endtask

    function automatic int q_size(input int id);
        if (id == 0) return q0.size();
        if (id == 1) return q1.size();
        return q2.size();
    endfunction

    function automatic exp_t q_pop(input int id);
        if (id == 0) return q0.pop_front();
        if (id == 1) return q1.pop_front();
        return q2.pop_front();
    endfunction

    task automatic mon(input int id, input logic en, input logic [1:0] dig,
                       input logic [3:0] val, input logic [1:0] own, input logic [3:0] ack);
        exp_t e;
        if (en || ack != 4'd0) begin
            chk($sformatf("sb%0d_pending", id), 32'(q_size(id) > 0), 32'd1);
            if (q_size(id) > 0) begin
                e = q_pop(id);
                if (en) begin
                    chk($sformatf("sb%0d_kind_write", id), 32'(e.is_ack), 32'd0);
                    chk($sformatf("sb%0d_dig", id), 32'(dig), 32'(e.dig));
                    chk($sformatf("sb%0d_val", id), 32'(val), 32'(e.val));
                    chk($sformatf("sb%0d_owner", id), 32'(own), 32'(e.owner));
                end else begin
                    chk($sformatf("sb%0d_kind_ack", id), 32'(e.is_ack), 32'd1);
                    chk($sformatf("sb%0d_ack", id), 32'(ack), 32'(4'd1 << e.owner));
                end
            end
        end
    endtask

    always @(negedge clk) if (!rst) mon(0, ia.hex_en, ia.hex_dig, ia.hex_val, ia.owner, 4'(ia.ack));
    always @(negedge clk) if (!rst) mon(1, ig.hex_en, ig.hex_dig, ig.hex_val, ig.owner, 4'(ig.ack));
    always @(negedge clk) if (!rst) mon(2, iq.hex_en, iq.hex_dig, iq.hex_val, iq.owner, 4'(iq.ack));

    initial begin
        rst = 1'b1;
        ia.req = '0; ia.data = '0;
        ig.req = '0; ig.data = '0;
        iq.req = '0; iq.data = '0;

        @(negedge clk);
        chk("rst_a_en",    32'(ia.hex_en),  32'd0);
        chk("rst_a_val",   32'(ia.hex_val), 32'd0);
        chk("rst_a_dig",   32'(ia.hex_dig), 32'd0);
        chk("rst_a_ack",   32'(ia.ack),     32'd0);
        chk("rst_a_busy",  32'(ia.busy),    32'd0);
        chk("rst_a_owner", 32'(ia.owner),   32'd0);
        chk("rst_g_en",    32'(ig.hex_en),  32'd0);
        chk("rst_q_busy",  32'(iq.busy),    32'd0);
        rst = 1'b0;

        // Single request: four writes then ack five cycles after the request.
        @(negedge clk);
        ia.req = 2'b01; ia.data = 32'h0000_1A3F;
        push_seq(0, 2'd0, 16'h1A3F, 4, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("single_en_k%0d", k),   32'(ia.hex_en), 32'(k <= 4));
            chk($sformatf("single_busy_k%0d", k), 32'(ia.busy),   32'd1);
            chk($sformatf("single_ack_k%0d", k),  32'(ia.ack),    (k == 5) ? 32'd1 : 32'd0);
            if (k == 5) ia.req = 2'b00;
        end
        @(negedge clk);
        chk("single_busy_after", 32'(ia.busy), 32'd0);

        // Fairness after reset: both requesting, grants alternate 0,1,0,1.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ia.req = 2'b11; ia.data = 32'hFFFF_0000;
        push_seq(0, 2'd0, 16'h0000, 4, 1'b1);
        push_seq(0, 2'd1, 16'hFFFF, 4, 1'b1);
        push_seq(0, 2'd0, 16'h0000, 4, 1'b1);
        push_seq(0, 2'd1, 16'hFFFF, 4, 1'b1);
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk);
            if (k % 6 == 1) chk($sformatf("fair_owner_k%0d", k), 32'(ia.owner), 32'((k / 6) % 2));
            if (k % 6 == 5) chk($sformatf("fair_ack_k%0d", k), 32'(ia.ack), 32'(2'b01 << ((k / 6) % 2)));
            if (k == 23) ia.req = 2'b00;
        end
        @(negedge clk);
        chk("fair_busy_after", 32'(ia.busy), 32'd0);

        // Data and req change after the first write; latched word still goes out.
        ia.req = 2'b01; ia.data[15:0] = 16'h1234;
        push_seq(0, 2'd0, 16'h1234, 4, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("mid_first_en", 32'(ia.hex_en), 32'd1);
                ia.data[15:0] = 16'hBEEF;
                ia.req = 2'b00;
            end
            if (k == 5) chk("mid_ack", 32'(ia.ack), 32'd1);
        end
        @(negedge clk);

        // Reset while digit 2 is on the bus; requester 0 wins first afterwards.
        ia.req = 2'b11; ia.data = {16'h5678, 16'h0000};
        push_seq(0, 2'd1, 16'h5678, 3, 1'b0);
        for (int k = 1; k <= 3; k++) @(negedge clk);
        chk("rstmid_dig", 32'(ia.hex_dig), 32'd2);
        chk("rstmid_owner", 32'(ia.owner), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_en",    32'(ia.hex_en),  32'd0);
        chk("rstmid_val",   32'(ia.hex_val), 32'd0);
        chk("rstmid_dig0",  32'(ia.hex_dig), 32'd0);
        chk("rstmid_ack",   32'(ia.ack),     32'd0);
        chk("rstmid_busy",  32'(ia.busy),    32'd0);
        chk("rstmid_owner0", 32'(ia.owner),  32'd0);
        @(negedge clk);
        chk("rstmid_hold_ack", 32'(ia.ack), 32'd0);
        rst = 1'b0;
        ia.data[15:0] = 16'hCAFE;
        push_seq(0, 2'd0, 16'hCAFE, 4, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) chk("postrst_owner", 32'(ia.owner), 32'd0);
            if (k == 5) begin
                chk("postrst_ack", 32'(ia.ack), 32'd1);
                ia.req = 2'b00;
            end
        end
        @(negedge clk);

        // GAP=2: enable pattern 1,0,0 repeated, ack at T+11.
        ig.req = 2'b01; ig.data[15:0] = 16'h4321;
        push_seq(1, 2'd0, 16'h4321, 4, 1'b1);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            chk($sformatf("gap_en_k%0d", k), 32'(ig.hex_en), 32'(k <= 10 && (k - 1) % 3 == 0));
            chk($sformatf("gap_ack_k%0d", k), 32'(ig.ack), (k == 11) ? 32'd1 : 32'd0);
            if (k == 11) ig.req = 2'b00;
        end
        @(negedge clk);

        // NREQ=4: after serving 1, req=1010 goes to 3 then back to 1.
        iq.req = 4'b0010; iq.data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        push_seq(2, 2'd1, 16'hBBBB, 4, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 5) begin
                chk("q4_first_ack", 32'(iq.ack), 32'h2);
                iq.req = 4'b0000;
            end
        end
        @(negedge clk);
        iq.req = 4'b1010;
        push_seq(2, 2'd3, 16'hDDDD, 4, 1'b1);
        push_seq(2, 2'd1, 16'hBBBB, 4, 1'b1);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1)  chk("q4_owner3", 32'(iq.owner), 32'd3);
            if (k == 5)  chk("q4_ack3",   32'(iq.ack),   32'h8);
            if (k == 7)  chk("q4_owner1", 32'(iq.owner), 32'd1);
            if (k == 11) begin
                chk("q4_ack1", 32'(iq.ack), 32'h2);
                iq.req = 4'b0000;
            end
        end
        @(negedge clk);
        @(negedge clk);

        chk("sb0_drained", 32'(q0.size()), 32'd0);
        chk("sb1_drained", 32'(q1.size()), 32'd0);
        chk("sb2_drained", 32'(q2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
